// File: rtl/ice40_io_cell.sv
// Behavioural model of one iCE40 programmable I/O cell: a bidirectional pad with
// configurable registered/DDR/latched input and output paths selected by PIN_TYPE.
module ice40_io_cell #(
  parameter logic [5:0] PIN_TYPE = 6'b1010_01
) (
  input  logic INPUT_CLK,
  input  logic RST_N,
  input  logic CLOCK_ENABLE,
  input  logic LATCH_INPUT_VALUE,
  input  logic OUTPUT_ENABLE,
  input  logic D_OUT_0,
  input  logic D_OUT_1,
  output logic D_IN_0,
  output logic D_IN_1,
  inout  wire  PACKAGE_PIN
);

  localparam logic [3:0] OutMode = PIN_TYPE[5:2];
  localparam logic [1:0] InMode  = PIN_TYPE[1:0];

  logic pad_in;
  logic in0_q, in0_d;
  logic in1_q, in1_d;
  logic hold_q, hold_d;
  logic out0_q, out0_d;
  logic out1_q, out1_d;
  logic oe_q, oe_d;
  logic in_frozen;
  logic ddr_data;
  logic pad_en;
  logic pad_val;

  // Loop-back: the input path always sees the resolved pad, even while driving it.
  assign pad_in = PACKAGE_PIN;

  always_comb begin
    in_frozen = (InMode == 2'b10) && LATCH_INPUT_VALUE;
    in0_d     = (CLOCK_ENABLE && !in_frozen) ? pad_in : in0_q;
    in1_d     = (CLOCK_ENABLE && !in_frozen) ? pad_in : in1_q;
    hold_d    = (CLOCK_ENABLE && !LATCH_INPUT_VALUE) ? pad_in : hold_q;
    out0_d    = CLOCK_ENABLE ? D_OUT_0 : out0_q;
    out1_d    = CLOCK_ENABLE ? D_OUT_1 : out1_q;
    oe_d      = CLOCK_ENABLE ? OUTPUT_ENABLE : oe_q;
  end

  always_ff @(posedge INPUT_CLK or negedge RST_N) begin
    if (!RST_N) begin
      in0_q  <= 1'b0;
      hold_q <= 1'b0;
      out0_q <= 1'b0;
      out1_q <= 1'b0;
      oe_q   <= 1'b0;
    end else begin
      in0_q  <= in0_d;
      hold_q <= hold_d;
      out0_q <= out0_d;
      out1_q <= out1_d;
      oe_q   <= oe_d;
    end
  end

  always_ff @(negedge INPUT_CLK or negedge RST_N) begin
    if (!RST_N) begin
      in1_q <= 1'b0;
    end else begin
      in1_q <= in1_d;
    end
  end

  always_comb begin
    D_IN_1 = in1_q;
    case (InMode)
      2'b00:   D_IN_0 = in0_q;
      2'b01:   D_IN_0 = pad_in;
      2'b10:   D_IN_0 = in0_q;
      default: D_IN_0 = LATCH_INPUT_VALUE ? hold_q : pad_in;
    endcase
  end

  assign ddr_data = INPUT_CLK ? out0_q : out1_q;

  always_comb begin
    pad_en  = 1'b0;
    pad_val = 1'b0;
    case (OutMode)
      4'b0110: begin pad_en = 1'b1;          pad_val = D_OUT_0;  end
      4'b0101: begin pad_en = 1'b1;          pad_val = out0_q;   end
      4'b0100: begin pad_en = 1'b1;          pad_val = ddr_data; end
      4'b1010: begin pad_en = OUTPUT_ENABLE; pad_val = D_OUT_0;  end
      4'b1001: begin pad_en = OUTPUT_ENABLE; pad_val = out0_q;   end
      4'b1101: begin pad_en = oe_q;          pad_val = out0_q;   end
      4'b1000: begin pad_en = OUTPUT_ENABLE; pad_val = ddr_data; end
      4'b1100: begin pad_en = oe_q;          pad_val = ddr_data; end
      default: begin pad_en = 1'b0;          pad_val = 1'b0;     end
    endcase
  end

  assign PACKAGE_PIN = pad_en ? pad_val : 1'bz;

endmodule

// File: tb/tb_ice40_io_cell.sv
// Directed bench: seven cells with different PIN_TYPEs share control inputs; each pad
// has a pull-up and an optional bench driver, so a released pad reads as 1.
module tb_ice40_io_cell;

  logic clk = 1'b0;
  logic rst_n, ce, latch, oe, d0, d1;
  logic [6:0] ext_en, ext_val;
  logic [6:0] din0, din1;
  wire pad_a, pad_b, pad_c, pad_d, pad_e, pad_f, pad_g;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign pad_a = ext_en[0] ? ext_val[0] : 1'bz;
  assign pad_b = ext_en[1] ? ext_val[1] : 1'bz;
  assign pad_c = ext_en[2] ? ext_val[2] : 1'bz;
  assign pad_d = ext_en[3] ? ext_val[3] : 1'bz;
  assign pad_e = ext_en[4] ? ext_val[4] : 1'bz;
  assign pad_f = ext_en[5] ? ext_val[5] : 1'bz;
  assign pad_g = ext_en[6] ? ext_val[6] : 1'bz;
  pullup (pad_a);
  pullup (pad_b);
  pullup (pad_c);
  pullup (pad_d);
  pullup (pad_e);
  pullup (pad_f);
  pullup (pad_g);

  ice40_io_cell #(.PIN_TYPE(6'b1010_01)) u_a (.INPUT_CLK(clk), .RST_N(rst_n),
    .CLOCK_ENABLE(ce), .LATCH_INPUT_VALUE(latch), .OUTPUT_ENABLE(oe), .D_OUT_0(d0),
    .D_OUT_1(d1), .D_IN_0(din0[0]), .D_IN_1(din1[0]), .PACKAGE_PIN(pad_a));
  ice40_io_cell #(.PIN_TYPE(6'b1010_00)) u_b (.INPUT_CLK(clk), .RST_N(rst_n),
    .CLOCK_ENABLE(ce), .LATCH_INPUT_VALUE(latch), .OUTPUT_ENABLE(oe), .D_OUT_0(d0),
    .D_OUT_1(d1), .D_IN_0(din0[1]), .D_IN_1(din1[1]), .PACKAGE_PIN(pad_b));
  ice40_io_cell #(.PIN_TYPE(6'b0101_01)) u_c (.INPUT_CLK(clk), .RST_N(rst_n),
    .CLOCK_ENABLE(ce), .LATCH_INPUT_VALUE(latch), .OUTPUT_ENABLE(oe), .D_OUT_0(d0),
    .D_OUT_1(d1), .D_IN_0(din0[2]), .D_IN_1(din1[2]), .PACKAGE_PIN(pad_c));
  ice40_io_cell #(.PIN_TYPE(6'b1101_00)) u_d (.INPUT_CLK(clk), .RST_N(rst_n),
    .CLOCK_ENABLE(ce), .LATCH_INPUT_VALUE(latch), .OUTPUT_ENABLE(oe), .D_OUT_0(d0),
    .D_OUT_1(d1), .D_IN_0(din0[3]), .D_IN_1(din1[3]), .PACKAGE_PIN(pad_d));
  ice40_io_cell #(.PIN_TYPE(6'b0100_01)) u_e (.INPUT_CLK(clk), .RST_N(rst_n),
    .CLOCK_ENABLE(ce), .LATCH_INPUT_VALUE(latch), .OUTPUT_ENABLE(oe), .D_OUT_0(d0),
    .D_OUT_1(d1), .D_IN_0(din0[4]), .D_IN_1(din1[4]), .PACKAGE_PIN(pad_e));
  ice40_io_cell #(.PIN_TYPE(6'b0000_11)) u_f (.INPUT_CLK(clk), .RST_N(rst_n),
    .CLOCK_ENABLE(ce), .LATCH_INPUT_VALUE(latch), .OUTPUT_ENABLE(oe), .D_OUT_0(d0),
    .D_OUT_1(d1), .D_IN_0(din0[5]), .D_IN_1(din1[5]), .PACKAGE_PIN(pad_f));
  ice40_io_cell #(.PIN_TYPE(6'b0000_10)) u_g (.INPUT_CLK(clk), .RST_N(rst_n),
    .CLOCK_ENABLE(ce), .LATCH_INPUT_VALUE(latch), .OUTPUT_ENABLE(oe), .D_OUT_0(d0),
    .D_OUT_1(d1), .D_IN_0(din0[6]), .D_IN_1(din1[6]), .PACKAGE_PIN(pad_g));

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; latch = 1'b0; oe = 1'b0; d0 = 1'b0; d1 = 1'b0;
    ext_en = '0; ext_val = '0;
    #1;
    check("rst_b_din0", din0[1], 1'b0);
    check("rst_b_din1", din1[1], 1'b0);
    check("rst_d_pad_released", pad_d, 1'b1);
    check("rst_c_pad", pad_c, 1'b0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("deassert_b_din0_still0", din0[1], 1'b0);

    // Simple output with combinational OE, simple input.
    oe = 1'b1; d0 = 1'b0; #1;
    check("a_drive0", pad_a, 1'b0);
    d0 = 1'b1; #1;
    check("a_drive1", pad_a, 1'b1);
    check("a_loopback", din0[0], 1'b1);
    oe = 1'b0; ext_en[0] = 1'b1; ext_val[0] = 1'b0; #1;
    check("a_ext0_pad", pad_a, 1'b0);
    check("a_ext0_din0", din0[0], 1'b0);
    ext_en[0] = 1'b0; d0 = 1'b0; #1;
    check("a_released", pad_a, 1'b1);

    // Registered DDR input.
    ext_en[1] = 1'b1; ext_val[1] = 1'b0;
    @(posedge clk); @(negedge clk); #2 ext_val[1] = 1'b1; #1;
    check("b_din0_not_yet", din0[1], 1'b0);
    @(posedge clk); #1;
    check("b_din0_rise1", din0[1], 1'b1);
    check("b_din1_before_neg", din1[1], 1'b0);
    @(negedge clk); #1;
    check("b_din1_fall1", din1[1], 1'b1);
    #1 ext_val[1] = 1'b0;
    @(posedge clk); #1;
    check("b_din0_rise0", din0[1], 1'b0);
    check("b_din1_hold1", din1[1], 1'b1);
    @(negedge clk); #1;
    check("b_din1_fall0", din1[1], 1'b0);
    #1 ext_val[1] = 1'b1;
    @(posedge clk); #1;
    check("b_din0_rise1b", din0[1], 1'b1);
    @(negedge clk); #1;
    check("b_din1_fall1b", din1[1], 1'b1);
    #1 rst_n = 1'b0; #1;
    check("b_async_rst_din0", din0[1], 1'b0);
    check("b_async_rst_din1", din1[1], 1'b0);
    rst_n = 1'b1; #1;
    check("b_after_rst_din0", din0[1], 1'b0);
    ext_en[1] = 1'b0;

    // Registered output and clock-enable freeze.
    @(posedge clk); #1;
    check("c_pad0", pad_c, 1'b0);
    @(negedge clk); d0 = 1'b1; #1;
    check("c_pad_waits", pad_c, 1'b0);
    @(posedge clk); #1;
    check("c_pad1", pad_c, 1'b1);
    @(negedge clk); ce = 1'b0; d0 = 1'b0;
    @(posedge clk); #1;
    check("c_ce_freeze", pad_c, 1'b1);
    @(negedge clk); ce = 1'b1;

    // Registered output with registered OE.
    oe = 1'b0;
    @(posedge clk); #1;
    check("d_released", pad_d, 1'b1);
    @(negedge clk); oe = 1'b1; #1;
    check("d_oe_not_yet", pad_d, 1'b1);
    @(posedge clk); #1;
    check("d_driven0", pad_d, 1'b0);
    #2 rst_n = 1'b0; #1;
    check("d_rst_released", pad_d, 1'b1);
    @(negedge clk); rst_n = 1'b1; oe = 1'b0;

    // DDR output.
    d0 = 1'b1; d1 = 1'b0;
    @(posedge clk); #1;
    check("e_high_phase1", pad_e, 1'b1);
    @(negedge clk); #1;
    check("e_low_phase0", pad_e, 1'b0);
    d0 = 1'b0; d1 = 1'b1; #1;
    check("e_low_old", pad_e, 1'b0);
    @(posedge clk); #1;
    check("e_inv_high0", pad_e, 1'b0);
    @(negedge clk); #1;
    check("e_inv_low1", pad_e, 1'b1);

    // Latched input.
    ext_en[5] = 1'b1; ext_val[5] = 1'b1; latch = 1'b0;
    @(posedge clk); #1;
    check("f_track1", din0[5], 1'b1);
    latch = 1'b1; ext_val[5] = 1'b0; #1;
    check("f_latched", din0[5], 1'b1);
    @(posedge clk); #1;
    check("f_latched_edge", din0[5], 1'b1);
    latch = 1'b0; #1;
    check("f_release", din0[5], 1'b0);
    @(negedge clk); #1;
    check("f_din1_neg", din1[5], 1'b0);

    // Registered input with hold.
    ext_en[6] = 1'b1; ext_val[6] = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    check("g_din0_1", din0[6], 1'b1);
    check("g_din1_1", din1[6], 1'b1);
    latch = 1'b1; ext_val[6] = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    check("g_hold_din0", din0[6], 1'b1);
    check("g_hold_din1", din1[6], 1'b1);
    latch = 1'b0;
    @(posedge clk); #1;
    check("g_unhold_din0", din0[6], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
